serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor computing diff = a - b for WIDTH-bit operands, one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow, trading latency for area. It is the inverse arithmetic companion to the team's half-adder/adder blocks. Operands enter and results leave through valid/ready handshakes.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair a/b is valid
in_ready  output  1  block can accept operands; high only in IDLE
a  input  WIDTH  minuend, unsigned
b  input  WIDTH  subtrahend, unsigned
out_valid  output  1  diff/borrow_out are valid; high only in DONE
out_ready  input  1  consumer accepts the result
diff  output  WIDTH  (a - b) mod 2^WIDTH
borrow_out  output  1  1 iff a < b (unsigned)
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: asynchronous on rst_n low; clk and rst_n are the only clock and reset.
  - State goes to IDLE; all registers clear.
  - Register set: a_sh, b_sh, d_sh, borrow_q, bit counter.
  - Outputs during and after reset: in_ready=1, out_valid=0, busy=0, diff=0, borrow_out=0.
- Reset mid-operation discards the operation in progress; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load a_sh=a, b_sh=b, borrow_q=0, cnt=0; go to RUN.
  - a and b are sampled only on that edge.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge, one full-subtractor step on x=a_sh[0], y=b_sh[0], bin=borrow_q.
    - d = x^y^bin
    - bout = (~x&y) | (~(x^y)&bin)
  - a_sh and b_sh shift right by 1.
  - d_sh shifts right with d entering at MSB.
  - borrow_q takes bout; cnt increments.
  - On the edge where cnt==WIDTH-1 (the last bit), go to DONE.
- Latency: accept edge at cycle k, bit edges at k+1..k+WIDTH, out_valid high in the cycle after edge k+WIDTH.
  - Accept edge to out_valid is exactly WIDTH cycles.
- DONE:
  - out_valid=1; diff=d_sh; borrow_out=borrow_q.
  - Outputs are held stable while out_ready=0, with unbounded backpressure.
  - On an edge with out_ready=1: go to IDLE; out_valid drops next cycle.
- diff and borrow_out are registered. They may hold stale values outside DONE, but are reset to 0; the bench checks them only when out_valid=1.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH bits, handoff). There is no overlap: in_ready=0 in DONE, even when out_ready=1.
- Counter width is max(1, $clog2(WIDTH)).
- WIDTH=1: RUN lasts exactly one edge.
- Arithmetic is modulo 2^WIDTH.
  - a==b gives diff=0, borrow_out=0.
  - a=0, b=2^WIDTH-1 gives diff=1, borrow_out=1.
- out_ready asserted outside DONE is ignored.

Decomposition:
- No shared package is needed. State encoding is a local 2-bit localparam set: IDLE=0, RUN=1, DONE=2; code 3 recovers to IDLE.
- Sub-module full_subtractor (combinational: x, y, bin -> d, bout), instantiated once. It is built from two half_subtractor instances (d=x^y, bout=~x&y) plus an OR of their borrows.
- half_subtractor is a standalone module and is unit-tested separately.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, out_ready=1 -> diff=0x23, borrow_out=0. out_valid rises exactly 8 cycles after the accept edge and lasts 1 cycle.
- WIDTH=8, a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; a=0xA5, b=0xA5 -> diff=0x00, borrow_out=0.
- Backpressure: a=0x80, b=0x7F, out_ready=0 for 5 cycles in DONE. Expect diff=0x01, borrow_out=0 held stable and in_ready=0 throughout. Raise out_ready, then expect IDLE with in_ready=1 the next cycle.
- in_valid held high with changing a/b during RUN -> operands ignored; result matches operands sampled at the accept edge. A second operation is accepted only after DONE handoff.
- Reset: drop rst_n for 1 cycle at bit 4 of a=0x10, b=0x20 -> outputs go to reset values immediately and out_valid never asserts. A following a=0x10, b=0x20 gives diff=0xF0, borrow_out=1.
- WIDTH=1 build: all four a/b combinations -> (0,0):0/0, (1,0):1/0, (0,1):1/1, (1,1):0/0. Latency is 1 cycle.

Source files
------------

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Purpose : single-bit x - y - bin, built from two half subtractors.
// Ports   : x    - minuend bit
//           y    - subtrahend bit
//           bin  - borrow in
//           d    - difference bit (x ^ y ^ bin)
//           bout - borrow out ((~x & y) | (~(x ^ y) & bin))
// -----------------------------------------------------------------------------
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d0;
   logic b0;
   logic b1;

   // First stage forms x - y; second stage subtracts the incoming borrow from
   // that partial difference. At most one stage can borrow, so OR suffices.
   half_subtractor u_hs0 (
      .x    (x),
      .y    (y),
      .d    (d0),
      .bout (b0)
   );

   half_subtractor u_hs1 (
      .x    (d0),
      .y    (bin),
      .d    (d),
      .bout (b1)
   );

   assign bout = b0 | b1;

endmodule

// File: rtl/half_subtractor.sv
// -----------------------------------------------------------------------------
// half_subtractor
// Purpose : single-bit difference of x - y with borrow.
// Ports   : x    - minuend bit
//           y    - subtrahend bit
//           d    - difference bit (x ^ y)
//           bout - borrow out, set when x=0 and y=1
// -----------------------------------------------------------------------------
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bout
);

   assign d    = x ^ y;
   assign bout = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Purpose : bit-serial unsigned subtractor, diff = a - b (mod 2^WIDTH), one bit
//           per clock LSB first, using one full-subtractor cell and a
//           registered borrow.
// Ports   : clk        - system clock, rising edge
//           rst_n      - asynchronous active-low reset
//           in_valid   - operand pair a/b is valid
//           in_ready   - operands can be accepted (IDLE only)
//           a, b       - minuend / subtrahend, unsigned WIDTH bits
//           out_valid  - diff/borrow_out valid (DONE only)
//           out_ready  - consumer accepts the result
//           diff       - (a - b) mod 2^WIDTH
//           borrow_out - 1 iff a < b
//           busy       - operation in RUN or DONE
// Latency : accept edge to out_valid is exactly WIDTH cycles; no overlap
//           between consecutive operations.
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             busy
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] d_sh;
   logic [WIDTH-1:0] d_sh_nx;
   logic             borrow_q;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             bout;

   full_subtractor u_fs (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .bin  (borrow_q),
      .d    (d),
      .bout (bout)
   );

   // Result bits enter at the MSB so that after WIDTH steps the LSB-first
   // stream sits in natural bit order.
   if (WIDTH == 1) begin : g_d_w1
      assign d_sh_nx = d;
   end else begin : g_d_wn
      assign d_sh_nx = {d, d_sh[WIDTH-1:1]};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // NOTE: every output of this block is given a default first so that no
   // path through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         // Unused encoding 3 falls back to IDLE.
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: operands are sampled only on the accept edge; during RUN the
   // shift registers advance one bit per edge. DONE holds everything, which
   // keeps diff/borrow_out stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         d_sh     <= '0;
         borrow_q <= 1'b0;
         cnt      <= '0;
      end else if (state == IDLE && in_valid) begin
         a_sh     <= a;
         b_sh     <= b;
         d_sh     <= '0;
         borrow_q <= 1'b0;
         cnt      <= '0;
      end else if (state == RUN) begin
         a_sh     <= a_sh >> 1;
         b_sh     <= b_sh >> 1;
         d_sh     <= d_sh_nx;
         borrow_q <= bout;
         cnt      <= cnt + 1'b1;
      end
   end

   // Both result outputs come straight from registers.
   assign diff       = d_sh;
   assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances) and
// for the half_subtractor leaf cell.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n;

   // WIDTH=8 instance
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] diff;
   logic       borrow_out;
   logic       busy;

   // WIDTH=1 instance
   logic       in_valid1;
   logic       in_ready1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       out_valid1;
   logic       out_ready1;
   logic [0:0] diff1;
   logic       borrow_out1;
   logic       busy1;

   // half_subtractor leaf
   logic       hx;
   logic       hy;
   logic       hd;
   logic       hb;

   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow_out (borrow_out),
      .busy       (busy)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid1),
      .in_ready   (in_ready1),
      .a          (a1),
      .b          (b1),
      .out_valid  (out_valid1),
      .out_ready  (out_ready1),
      .diff       (diff1),
      .borrow_out (borrow_out1),
      .busy       (busy1)
   );

   half_subtractor u_hs (
      .x    (hx),
      .y    (hy),
      .d    (hd),
      .bout (hb)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Runs one WIDTH=8 operation. Called at #1 after a rising edge with the
   // DUT in IDLE. stall = cycles of out_ready=0 held in DONE; hold_valid keeps
   // in_valid high with scrambled operands while the operation is in flight.
   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic [7:0] exp_d, input logic exp_b,
                         input int stall, input bit hold_valid);
      int cyc;
      bit rdy_seen;
      a         = ta;
      b         = tb;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      if (!hold_valid) in_valid = 1'b0;
      cyc      = 0;
      rdy_seen = 1'b0;
      while (!out_valid && cyc < 20) begin
         if (hold_valid) begin
            a = 8'($urandom);
            b = 8'($urandom);
         end
         @(posedge clk); #1;
         cyc++;
         if (in_ready) rdy_seen = 1'b1;
      end
      in_valid = 1'b0;
      check({tag, "_latency"}, cyc, 8);
      check({tag, "_diff"}, diff, exp_d);
      check({tag, "_borrow"}, borrow_out, exp_b);
      check({tag, "_no_ready_busy"}, rdy_seen, 0);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         check({tag, "_hold"}, {out_valid, in_ready, busy, borrow_out, diff},
               {1'b1, 1'b0, 1'b1, exp_b, exp_d});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, "_handoff"}, {out_valid, in_ready, busy}, {1'b0, 1'b1, 1'b0});
   endtask

   task automatic run_op1(input logic ta, input logic tb, input logic exp_d, input logic exp_b);
      a1         = ta;
      b1         = tb;
      in_valid1  = 1'b1;
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      check("w1_running", {out_valid1, in_ready1, busy1}, {1'b0, 1'b0, 1'b1});
      @(posedge clk); #1;
      check("w1_result", {out_valid1, borrow_out1, diff1}, {1'b1, exp_b, exp_d});
      @(posedge clk); #1;
      check("w1_handoff", {out_valid1, in_ready1}, {1'b0, 1'b1});
   endtask

   initial begin
      bit seen;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      out_ready  = 1'b0;
      in_valid1  = 1'b0;
      a1         = '0;
      b1         = '0;
      out_ready1 = 1'b0;
      hx         = 1'b0;
      hy         = 1'b0;

      // Leaf cell truth table: {bout, d} for x - y.
      for (int i = 0; i < 4; i++) begin
         logic [1:0] exp_hs;
         hx = i[1];
         hy = i[0];
         case (i)
            0:       exp_hs = 2'b00;
            1:       exp_hs = 2'b11;
            2:       exp_hs = 2'b01;
            default: exp_hs = 2'b00;
         endcase
         #1;
         check("half_sub", {hb, hd}, exp_hs);
      end

      // Reset state
      #12;
      check("reset_w8", {in_ready, out_valid, busy, borrow_out, diff},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      check("reset_w1", {in_ready1, out_valid1, busy1, borrow_out1, diff1},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("basic",    8'h35, 8'h12, 8'h23, 1'b0, 0, 1'b0);
      run_op("underflow", 8'h00, 8'h01, 8'hFF, 1'b1, 0, 1'b0);
      run_op("equal",    8'hA5, 8'hA5, 8'h00, 1'b0, 0, 1'b0);
      run_op("zero_max", 8'h00, 8'hFF, 8'h01, 1'b1, 0, 1'b0);
      run_op("backpres", 8'h80, 8'h7F, 8'h01, 1'b0, 5, 1'b0);
      run_op("hold_vld", 8'h5A, 8'h3C, 8'h1E, 1'b0, 0, 1'b1);
      run_op("after_hv", 8'hC3, 8'h44, 8'h7F, 1'b0, 0, 1'b0);

      // Reset in the middle of a=0x10, b=0x20 at bit 4.
      a         = 8'h10;
      b         = 8'h20;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", {in_ready, out_valid, busy, borrow_out, diff},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("midrst_no_valid", seen, 0);
      run_op("post_rst", 8'h10, 8'h20, 8'hF0, 1'b1, 0, 1'b0);

      // WIDTH=1 instance, all operand combinations.
      run_op1(1'b0, 1'b0, 1'b0, 1'b0);
      run_op1(1'b1, 1'b0, 1'b1, 1'b0);
      run_op1(1'b0, 1'b1, 1'b1, 1'b1);
      run_op1(1'b1, 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
